// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the gate vector sequencer: FSM state encoding
// and the vector-count function used to size the truth table.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int num_vec(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Counts the clocks each vector is held; last flags the sampling cycle.
module hold_counter #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic last
);

  localparam int W = $clog2(HOLD_CYCLES + 1);

  logic [W-1:0] cnt_q;

  assign last = (cnt_q == W'(HOLD_CYCLES - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Sweeps every input combination of a small gate DUT, samples its output on
// the last hold cycle of each vector and accumulates pass/fail results.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int                          N_IN        = 2,
  parameter int                          HOLD_CYCLES = 10,
  parameter logic [num_vec(N_IN)-1:0]    TRUTH       = 4'b1110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(num_vec(N_IN) - 1);

  state_e          state_q;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic [N_IN:0]   err_d;
  logic [N_IN-1:0] ffv_q;
  logic            fail_seen_q;
  logic            mismatch;
  logic            start_accept;
  logic            hold_last;

  assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));

  hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(start_accept),
    .tick (state_q == APPLY),
    .last (hold_last)
  );

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mismatch = 1'b0;
    err_d    = err_q;
    mismatch = (dut_out != TRUTH[vec_q]);
    err_d    = err_q + (N_IN + 1)'(mismatch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ffv_q       <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= APPLY;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            vec_q       <= '0;
            err_q       <= '0;
            ffv_q       <= '0;
            fail_seen_q <= 1'b0;
          end
        end
        APPLY: begin
          if (hold_last) begin
            if (mismatch) begin
              err_q <= err_d;
              if (!fail_seen_q) begin
                ffv_q       <= vec_q;
                fail_seen_q <= 1'b1;
              end
            end
            // pass must include the sample taken on this final edge
            if (vec_q == LAST_VEC) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              vec_q   <= '0;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_out        = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: two instances (OR defaults, XOR3 fast sweep),
// a behavioural gate model per mode and a scoreboard of expected sweep results.
module tb_gate_vector_sequencer;

  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [7:0] TRUTH_XOR3 = 8'h96;

  typedef struct {
    int err;
    int ffv;
    int pass;
    int cycles;
  } result_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   mode_a = 0;  // 0 OR, 1 AND, 2 stuck-at-1

  logic [1:0] vec_a;
  logic       dout_a, busy_a, done_a, pass_a;
  logic [2:0] err_a;
  logic [1:0] ffv_a;

  logic [2:0] vec_b;
  logic       dout_b, busy_b, done_b, pass_b;
  logic [3:0] err_b;
  logic [2:0] ffv_b;

  int n_checks = 0;
  int n_errors = 0;
  result_t sb_q[$];

  always #5 clk = ~clk;

  function automatic logic model_a(input int m, input logic [1:0] v);
    case (m)
      0:       return v[0] | v[1];
      1:       return v[0] & v[1];
      default: return 1'b1;
    endcase
  endfunction

  assign dout_a = model_a(mode_a, vec_a);
  assign dout_b = vec_b[0] ^ vec_b[1] ^ vec_b[2];

  gate_vector_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec_out(vec_a), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail_vec(ffv_a)
  );

  gate_vector_sequencer #(.N_IN(3), .HOLD_CYCLES(1), .TRUTH(TRUTH_XOR3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec_out(vec_b), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail_vec(ffv_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observed signals of the selected instance (0 = A, 1 = B)
  function automatic int o_vec(input int sel);  return sel ? int'(vec_b)  : int'(vec_a);  endfunction
  function automatic int o_busy(input int sel); return sel ? int'(busy_b) : int'(busy_a); endfunction
  function automatic int o_done(input int sel); return sel ? int'(done_b) : int'(done_a); endfunction
  function automatic int o_pass(input int sel); return sel ? int'(pass_b) : int'(pass_a); endfunction
  function automatic int o_err(input int sel);  return sel ? int'(err_b)  : int'(err_a);  endfunction
  function automatic int o_ffv(input int sel);  return sel ? int'(ffv_b)  : int'(ffv_a);  endfunction

  function automatic result_t expect_sweep(input int sel, input int m);
    result_t r;
    int nvec;
    logic exp_bit, got_bit;
    r.err = 0; r.ffv = 0; r.pass = 0;
    nvec  = sel ? 8 : 4;
    r.cycles = nvec * (sel ? 1 : 10);
    for (int v = 0; v < nvec; v++) begin
      if (sel) begin
        exp_bit = TRUTH_XOR3[v];
        got_bit = ^v[2:0];
      end else begin
        exp_bit = TRUTH_OR[v];
        got_bit = model_a(m, v[1:0]);
      end
      if (got_bit != exp_bit) begin
        if (r.err == 0) r.ffv = v;
        r.err++;
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic pulse_start(input int sel, input logic val);
    if (sel) start_b = val; else start_a = val;
  endtask

  task automatic run_sweep(input int sel, input int m, input int glitch_at);
    result_t exp_r, got_r;
    int k;
    int hold;
    string nm;
    nm   = sel ? "B" : "A";
    hold = sel ? 1 : 10;
    if (!sel) mode_a = m;
    sb_q.push_back(expect_sweep(sel, m));
    @(negedge clk);
    pulse_start(sel, 1'b1);
    @(posedge clk); #1;
    pulse_start(sel, 1'b0);
    k = 0;
    check({nm, " busy after start"}, o_busy(sel), 1);
    check({nm, " done cleared on start"}, o_done(sel), 0);
    check({nm, " err cleared on start"}, o_err(sel), 0);
    check({nm, " ffv cleared on start"}, o_ffv(sel), 0);
    check({nm, " vec0 on start"}, o_vec(sel), 0);
    while (o_done(sel) == 0 && k < 200) begin
      if (glitch_at != 0 && k == glitch_at - 1) pulse_start(sel, 1'b1);
      @(posedge clk); #1;
      k++;
      pulse_start(sel, 1'b0);
      if (o_done(sel) == 0) check({nm, " vec_out sequence"}, o_vec(sel), k / hold);
    end
    if (sb_q.size() == 0) begin
      check({nm, " scoreboard not empty"}, 0, 1);
    end else begin
      exp_r = sb_q.pop_front();
      got_r.err = o_err(sel); got_r.ffv = o_ffv(sel);
      got_r.pass = o_pass(sel); got_r.cycles = k;
      check({nm, " cycles to done"}, got_r.cycles, exp_r.cycles);
      check({nm, " err_count"}, got_r.err, exp_r.err);
      check({nm, " first_fail_vec"}, got_r.ffv, exp_r.ffv);
      check({nm, " pass"}, got_r.pass, exp_r.pass);
      check({nm, " busy low at done"}, o_busy(sel), 0);
      check({nm, " vec back to 0"}, o_vec(sel), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " vec"},  int'(vec_a),  0);
    check({tag, " busy"}, int'(busy_a), 0);
    check({tag, " done"}, int'(done_a), 0);
    check({tag, " pass"}, int'(pass_a), 0);
    check({tag, " err"},  int'(err_a),  0);
    check({tag, " ffv"},  int'(ffv_a),  0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep(0, 0, 5);  // OR model; stray start at clk 5 must not disturb timing
    check("A done held", int'(done_a), 1);
    run_sweep(0, 1, 0);  // AND model: vectors 1 and 2 fail
    run_sweep(0, 2, 0);  // stuck-at-1: only vector 0 fails

    // Reset mid-sweep clears everything without a clock edge
    mode_a = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check("A busy before abort", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 0, 0);

    run_sweep(1, 3, 0);
    check("B pass after first sweep", int'(pass_b), 1);
    run_sweep(1, 3, 0);  // restart from DONE

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
